vec_store_seq: RTL and testbench

VEC_STORE_SEQ -- requirements
Module: vec_store_seq

---
 rtl/vec_store_seq_if.sv | 39 +++
 rtl/vec_store_seq.sv | 112 +++++++++++
 tb/tb_vec_store_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vec_store_seq_if.sv
// vec_store_seq_if: core/memory-side bus of the vector store sequencer.
// LaneMask exists only when VEC_STORE_LANE_MASK_EN is defined.
interface vec_store_seq_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned LANES  = 5,
   parameter int unsigned ADDR_W = 32
);
   logic                   Start;
   logic [ADDR_W-1:0]      BaseAddr;
   logic [ADDR_W-1:0]      Stride;
   logic [LANES*WIDTH-1:0] VecData;
`ifdef VEC_STORE_LANE_MASK_EN
   logic [LANES-1:0]       LaneMask;
`endif
   logic                   MemReady;
   logic                   MemWrite;
   logic [ADDR_W-1:0]      DataAdr;
   logic [WIDTH-1:0]       WriteData;
   logic                   Busy;
   logic                   Done;

   // Core and memory side: issues requests, grants writes, observes the sequencer.
   modport master (
`ifdef VEC_STORE_LANE_MASK_EN
      output LaneMask,
`endif
      output Start, BaseAddr, Stride, VecData, MemReady,
      input  MemWrite, DataAdr, WriteData, Busy, Done
   );

   // Sequencer side.
   modport slave (
`ifdef VEC_STORE_LANE_MASK_EN
      input  LaneMask,
`endif
      input  Start, BaseAddr, Stride, VecData, MemReady,
      output MemWrite, DataAdr, WriteData, Busy, Done
   );
endinterface

// File: rtl/vec_store_seq.sv
// vec_store_seq: writes one LANES-wide vector to memory, one lane per accepted cycle,
// at BaseAddr + k*Stride (modulo 2^ADDR_W). Optional per-lane write mask is enabled
// by defining VEC_STORE_LANE_MASK_EN.
module vec_store_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned LANES  = 5,
   parameter int unsigned ADDR_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   vec_store_seq_if.slave bus
);
   localparam int unsigned      LaneW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

   typedef enum logic [1:0] {StIdle, StStore, StDone} state_e;

   state_e                 state_q, state_d;
   logic [LaneW-1:0]       lane_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [ADDR_W-1:0]      stride_q;
   // Lane data is shifted down on each acceptance so the current lane is always at the bottom.
   logic [LANES*WIDTH-1:0] data_q;
   logic                   lane_en;
   logic                   capture;
   logic                   advance;

`ifdef VEC_STORE_LANE_MASK_EN
   logic [LANES-1:0] mask_q;

   // Captured lane mask, shifted in step with the lane data.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
      end else if (capture) begin
         mask_q <= bus.LaneMask;
      end else if (advance) begin
         mask_q <= mask_q >> 1;
      end
   end

   assign lane_en = mask_q[0];
`else
   assign lane_en = 1'b1;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and registered-state-driven outputs.
   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      advance       = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.DataAdr   = '0;
      bus.WriteData = '0;
      bus.Busy      = 1'b1;
      bus.Done      = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.Busy = 1'b0;
            if (bus.Start) begin
               capture = 1'b1;
               state_d = StStore;
            end
         end
         StStore: begin
            bus.MemWrite  = lane_en;
            bus.DataAdr   = addr_q;
            bus.WriteData = data_q[WIDTH-1:0];
            // Masked-off lanes never wait on memory.
            if (bus.MemReady || !lane_en) begin
               advance = 1'b1;
               if (lane_q == LastLane) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            bus.Done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Operand capture and per-lane advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q   <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         data_q   <= '0;
      end else if (capture) begin
         lane_q   <= '0;
         addr_q   <= bus.BaseAddr;
         stride_q <= bus.Stride;
         data_q   <= bus.VecData;
      end else if (advance) begin
         lane_q   <= lane_q + 1'b1;
         addr_q   <= addr_q + stride_q;
         data_q   <= data_q >> WIDTH;
      end
   end
endmodule

// File: tb/tb_vec_store_seq.sv
// tb_vec_store_seq: directed and randomized checks of vec_store_seq against a
// lane-count model (lane k written at base + k*stride once memory accepts it).
module tb_vec_store_seq;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned LANES  = 5;
   localparam int unsigned ADDR_W = 32;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   vec_store_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

   vec_store_seq #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag, input logic busy);
      check({tag, ".busy"}, 64'(bus.Busy), 64'(busy));
      check({tag, ".done"}, 64'(bus.Done), 64'd0);
      check({tag, ".memwrite"}, 64'(bus.MemWrite), 64'd0);
      check({tag, ".adr"}, 64'(bus.DataAdr), 64'd0);
      check({tag, ".wdata"}, 64'(bus.WriteData), 64'd0);
   endtask

   // Launch one vector and follow it to completion. stall_at forces MemReady=0 on that
   // STORE cycle (0 = none); exp_done, when non-zero, is the required Done cycle.
   task automatic run_vec(input string tag, input logic [ADDR_W-1:0] base,
                          input logic [ADDR_W-1:0] stride, input bit seq_data,
                          input int ready_pct, input int stall_at, input bit hold_start,
                          input logic [LANES-1:0] mask, input int exp_done);
      logic [WIDTH-1:0]       lane [LANES];
      logic [LANES*WIDTH-1:0] packed_data;
      logic [ADDR_W-1:0]      exp_addr;
      int                     accepted = 0;
      int                     cyc = 1;
      bit                     rdy;
      for (int k = 0; k < LANES; k++) begin
         lane[k] = seq_data ? WIDTH'(k + 1) : $urandom;
         packed_data[k*WIDTH +: WIDTH] = lane[k];
      end
      bus.BaseAddr = base;
      bus.Stride   = stride;
      bus.VecData  = packed_data;
`ifdef VEC_STORE_LANE_MASK_EN
      bus.LaneMask = mask;
`endif
      bus.MemReady = 1'b1;
      bus.Start    = 1'b1;
      tick();
      while (accepted < LANES) begin
         if (hold_start) begin
            // Operands change under a held Start; the sequencer must ignore them.
            bus.BaseAddr = $urandom;
            bus.Stride   = $urandom;
            bus.VecData  = ~bus.VecData;
`ifdef VEC_STORE_LANE_MASK_EN
            bus.LaneMask = ~bus.LaneMask;
`endif
         end else begin
            bus.Start = 1'b0;
         end
         exp_addr = base + stride * ADDR_W'(accepted);
         check({tag, ".busy"}, 64'(bus.Busy), 64'd1);
         check({tag, ".done_early"}, 64'(bus.Done), 64'd0);
         check({tag, ".memwrite"}, 64'(bus.MemWrite), 64'(mask[accepted]));
         check({tag, ".adr"}, 64'(bus.DataAdr), 64'(exp_addr));
         check({tag, ".wdata"}, 64'(bus.WriteData), 64'(lane[accepted]));
         if (cyc == stall_at) rdy = 1'b0;
         else rdy = ($urandom_range(99) < ready_pct) || (cyc > 30);
         bus.MemReady = rdy;
         if (rdy || !mask[accepted]) accepted++;
         tick();
         cyc++;
      end
      if (exp_done != 0) check({tag, ".done_cycle"}, 64'(cyc), 64'(exp_done));
      check({tag, ".done"}, 64'(bus.Done), 64'd1);
      check({tag, ".done_busy"}, 64'(bus.Busy), 64'd1);
      check({tag, ".done_memwrite"}, 64'(bus.MemWrite), 64'd0);
      check({tag, ".done_adr"}, 64'(bus.DataAdr), 64'd0);
      // Start may still be high here; it must not be captured from DONE.
      tick();
      bus.Start    = 1'b0;
      bus.MemReady = 1'b0;
      check_quiet({tag, ".after"}, 1'b0);
   endtask

   initial begin
      logic [LANES-1:0] all_lanes;
      all_lanes     = '1;
      reset         = 1'b1;
      bus.Start     = 1'b0;
      bus.MemReady  = 1'b0;
      bus.BaseAddr  = '0;
      bus.Stride    = '0;
      bus.VecData   = '0;
`ifdef VEC_STORE_LANE_MASK_EN
      bus.LaneMask  = '0;
`endif
      tick();
      tick();
      check_quiet("reset", 1'b0);
      reset = 1'b0;
      tick();
      check_quiet("idle", 1'b0);

      // Basic vector, then single stall on the second lane.
      run_vec("basic", 32'h100, 32'd4, 1'b1, 100, 0, 1'b0, all_lanes, 6);
      run_vec("stall", 32'h100, 32'd4, 1'b1, 100, 2, 1'b0, all_lanes, 7);
      // Address wrap past all-ones.
      run_vec("wrap", 32'hFFFF_FFF8, 32'd4, 1'b1, 100, 0, 1'b0, all_lanes, 6);
      // Start held across the whole operation.
      run_vec("hold", 32'h2000, 32'd8, 1'b0, 100, 0, 1'b1, all_lanes, 6);

      // Reset in the middle of a vector abandons it.
      bus.BaseAddr = 32'h100;
      bus.Stride   = 32'd4;
      bus.MemReady = 1'b1;
      bus.Start    = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_quiet("midreset", 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check({"midreset.no_done"}, 64'(bus.Done), 64'd0);
         check({"midreset.no_write"}, 64'(bus.MemWrite), 64'd0);
      end
      run_vec("post_reset", 32'h100, 32'd4, 1'b1, 100, 0, 1'b0, all_lanes, 6);

      // Randomized operands and memory back-pressure.
      for (int i = 0; i < 8; i++) begin
         run_vec("rand", $urandom, $urandom, 1'b0, 60, 0, 1'b0, all_lanes, 0);
      end

`ifdef VEC_STORE_LANE_MASK_EN
      run_vec("mask10101", 32'h100, 32'd4, 1'b1, 100, 0, 1'b0, 5'b10101, 6);
      run_vec("mask_zero", 32'h300, 32'd4, 1'b1, 50, 0, 1'b0, 5'b00000, 6);
      for (int i = 0; i < 6; i++) begin
         run_vec("mask_rand", $urandom, $urandom, 1'b0, 50, 0, 1'b0, LANES'($urandom), 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
